// File: rtl/cmp_share_sched.sv
// cmp_share_sched: shares one pipelined FP less-or-equal comparator among
// NREQ slab-test requesters. Requests are arbitrated, issued one per cycle,
// tagged with the requester ID and collected into a show-ahead response
// FIFO. Grants are credit-limited so a comparator result is never dropped.
// Build option: define CMP_SHARE_RR_EN for round-robin arbitration; the
// default build uses fixed priority (lowest requester index wins).
module cmp_share_sched #(
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int WIDTH      = 21,
    parameter int LAT        = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*(WIDTH+1)-1:0] req_a,
    input  logic [NREQ*(WIDTH+1)-1:0] req_b,
    output logic                      cmp_issue,
    output logic [WIDTH:0]            cmp_a,
    output logic [WIDTH:0]            cmp_b,
    input  logic                      cmp_le,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic                      rsp_le
);

    localparam int OW  = WIDTH + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CRW = $clog2(FIFO_DEPTH + LAT + 2) + 1;

    logic              issue_r;
    logic [IDW-1:0]    issue_id;
    logic [OW-1:0]     cmp_a_r;
    logic [OW-1:0]     cmp_b_r;
    logic [LAT-1:0]    tag_vld;
    logic [IDW-1:0]    tag_id [LAT];
    logic [IDW:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       fifo_cnt;
    logic              push;
    logic              pop;
    logic [CRW-1:0]    in_flight;
    logic [CRW-1:0]    occupancy;
    logic              credit_ok;
    logic              grant_any;
    logic [IDW-1:0]    grant_id;
    logic [OW-1:0]     sel_a;
    logic [OW-1:0]     sel_b;
`ifdef CMP_SHARE_RR_EN
    logic [IDW-1:0]    rr_ptr;
`endif

    assign push      = tag_vld[LAT-1];
    assign pop       = (fifo_cnt != '0) && rsp_ready;
    assign rsp_valid = (fifo_cnt != '0);
    assign rsp_id    = fifo_mem[rd_ptr][IDW:1];
    assign rsp_le    = fifo_mem[rd_ptr][0];
    assign cmp_issue = issue_r;
    assign cmp_a     = cmp_a_r;
    assign cmp_b     = cmp_b_r;

    // Outstanding compares: the issue register plus every valid tag stage.
    // The issue register holds a compare that has not reached the tag pipe
    // yet, so it must be counted or the FIFO could be overcommitted by one.
    always_comb begin
        in_flight = CRW'(issue_r);
        for (int i = 0; i < LAT; i++) begin
            in_flight = in_flight + CRW'(tag_vld[i]);
        end
    end

    assign occupancy = CRW'(fifo_cnt) - CRW'(pop) + in_flight;
    assign credit_ok = occupancy < CRW'(FIFO_DEPTH);

`ifdef CMP_SHARE_RR_EN
    // Round-robin grant: first valid requester at or after rr_ptr.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        if (!rst && credit_ok) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!grant_any && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                    grant_any = 1'b1;
                    grant_id  = IDW'((int'(rr_ptr) + k) % NREQ);
                end
            end
        end
    end
`else
    // Fixed-priority grant: lowest valid index wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        if (!rst && credit_ok) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req_valid[k]) begin
                    grant_any = 1'b1;
                    grant_id  = IDW'(k);
                end
            end
        end
    end
`endif

    assign req_ready = grant_any ? (NREQ'(1) << grant_id) : '0;
    assign sel_a     = req_a[int'(grant_id)*OW +: OW];
    assign sel_b     = req_b[int'(grant_id)*OW +: OW];

    // Issue register: launch the granted operands; operands hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_r  <= 1'b0;
            issue_id <= '0;
            cmp_a_r  <= '0;
            cmp_b_r  <= '0;
        end else begin
            issue_r <= grant_any;
            if (grant_any) begin
                issue_id <= grant_id;
                cmp_a_r  <= sel_a;
                cmp_b_r  <= sel_b;
            end
        end
    end

    // Tag pipe: last stage lines up with the comparator's cmp_le output.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_vld[0] <= issue_r;
            tag_id[0]  <= issue_r ? issue_id : '0;
            for (int i = 1; i < LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    // Response FIFO: push {id, le} on tag output, pop on rsp handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {tag_id[LAT-1], cmp_le};
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef CMP_SHARE_RR_EN
    // Round-robin pointer: next search starts just past the last grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
        end
    end
`endif

endmodule
